// File: rtl/ram_bus_arbiter.sv
// Shares one single-port synchronous RAM between NUM_REQ masters: round-robin
// arbitration, one access at a time, req/ack handshake, lock-extended bursts.
// Define ARB_FIXED_PRIO_EN to switch to fixed priority (lowest index wins).
module ram_bus_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  output logic                      ram_we,
  output logic                      ram_re,
  input  logic [DATA_W-1:0]         ram_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_owner;
  logic [CNT_W-1:0]    r_burst_cnt;
  logic                r_is_read;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic                r_ram_we;
  logic                r_ram_re;
  logic [DATA_W-1:0]   r_rdata_hold;

  logic [NUM_REQ-1:0]  w_owner_1h;
  logic [NUM_REQ-1:0]  w_cand;
  logic [IDX_W-1:0]    w_start;
  logic                w_found;
  logic [IDX_W-1:0]    w_win;
  logic                w_burst_go;
  logic                w_issue;
  logic [IDX_W-1:0]    w_sel;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  assign w_owner_1h = NUM_REQ'(1) << r_owner;

  // The owner just served is excluded from the arbitration made in DONE only.
  assign w_cand = req & ~((r_state == S_DONE) ? w_owner_1h : '0);

`ifdef ARB_FIXED_PRIO_EN
  assign w_start = '0;
`else
  logic [IDX_W-1:0] r_last_owner;
  logic [IDX_W-1:0] w_base;

  // In DONE the current owner becomes last_owner on this same edge.
  assign w_base  = (r_state == S_DONE) ? r_owner : r_last_owner;
  assign w_start = (w_base == IDX_W'(NUM_REQ - 1)) ? '0 : w_base + IDX_W'(1);
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_cand[IDX_W'((int'(w_start) + i) % NUM_REQ)]) begin
        w_found = 1'b1;
        w_win   = IDX_W'((int'(w_start) + i) % NUM_REQ);
      end
    end
  end

  assign w_burst_go = (r_state == S_DONE) && lock[r_owner] && req[r_owner] &&
                      (r_burst_cnt < CNT_W'(MAX_BURST - 1));

  assign w_issue = ((r_state == S_IDLE) && w_found) ||
                   ((r_state == S_DONE) && (w_burst_go || w_found));

  assign w_sel       = w_burst_go ? r_owner : w_win;
  assign w_sel_we    = we[w_sel];
  assign w_sel_addr  = addr[int'(w_sel)*ADDR_W +: ADDR_W];
  assign w_sel_wdata = wdata[int'(w_sel)*DATA_W +: DATA_W];

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_burst_cnt  <= '0;
      r_is_read    <= 1'b0;
      r_gnt        <= '0;
      r_ack        <= '0;
      r_busy       <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_ram_we     <= 1'b0;
      r_ram_re     <= 1'b0;
      r_rdata_hold <= '0;
`ifndef ARB_FIXED_PRIO_EN
      r_last_owner <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      r_ack    <= '0;
      r_ram_we <= 1'b0;
      r_ram_re <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_gnt  <= '0;
          r_busy <= 1'b0;
        end
        S_ISSUE: begin
          r_ack   <= w_owner_1h;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (r_is_read) r_rdata_hold <= ram_rdata;
          if (w_burst_go) begin
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
          end else begin
`ifndef ARB_FIXED_PRIO_EN
            r_last_owner <= r_owner;
`endif
            r_burst_cnt <= '0;
            r_gnt       <= '0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // NOTE: with non-blocking assignments the last one in the block wins, so
      // this issue path overrides the per-state defaults written above.
      if (w_issue) begin
        r_state     <= S_ISSUE;
        r_owner     <= w_sel;
        r_gnt       <= NUM_REQ'(1) << w_sel;
        r_busy      <= 1'b1;
        r_ram_addr  <= w_sel_addr;
        r_ram_wdata <= w_sel_wdata;
        r_ram_we    <= w_sel_we;
        r_ram_re    <= ~w_sel_we;
        r_is_read   <= ~w_sel_we;
      end
    end
  end

  // Read data passes straight through during the ack cycle and is held after.
  assign rdata     = ((r_state == S_DONE) && r_is_read) ? ram_rdata : r_rdata_hold;
  assign gnt       = r_gnt;
  assign ack       = r_ack;
  assign busy      = r_busy;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_we    = r_ram_we;
  assign ram_re    = r_ram_re;

endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Shares the single-port synchronous RAM between up to NUM_REQ bus masters: CPU control unit (port 0), video fetch (port 1), DMA/loader (port 2).
- Provides round-robin arbitration, a one-access-at-a-time issue FSM, a req/ack handshake and optional locked bursts.
- Sits between the masters and the RAM macro and owns all RAM address, data and strobe lines.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 16, RAM address width
- DATA_W, 16, RAM data width
- MAX_BURST, 4, maximum consecutive accesses one requester may hold via lock (1..15)

Ports:
- CLK  input  1  system clock, all logic on posedge
- RESET_N  input  1  synchronous active-low reset
- req  input  NUM_REQ  per-requester access request, held until ack
- lock  input  NUM_REQ  per-requester request to keep ownership for the next access
- we  input  NUM_REQ  per-requester write enable (1 = write, 0 = read)
- addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- wdata  input  NUM_REQ*DATA_W  packed write data, same packing
- gnt  output  NUM_REQ  one-hot current owner, registered
- ack  output  NUM_REQ  one-cycle completion pulse to the owner
- rdata  output  DATA_W  read data, valid only while ack is high for a read
- busy  output  1  high in ISSUE and DONE
- ram_addr  output  ADDR_W  registered RAM address
- ram_wdata  output  DATA_W  registered RAM write data
- ram_we  output  1  RAM write strobe
- ram_re  output  1  RAM read strobe
- ram_rdata  input  DATA_W  RAM read data, valid the cycle after ram_re

Behaviour:
- Reset (RESET_N low at a posedge) drives all outputs to 0 and sets state to IDLE, last_owner to NUM_REQ-1 and burst_cnt to 0. Reset during ISSUE aborts the access: ram_we/ram_re are 0 from the next cycle and no ack is issued.
- States:
  - IDLE: if any req bit is set, pick the winner round-robin starting at (last_owner+1) mod NUM_REQ. Register gnt = onehot(winner), ram_addr, ram_wdata, ram_we = we[w], ram_re = ~we[w]. Go to ISSUE. If no req is set, stay in IDLE with gnt = 0.
  - ISSUE: exactly one cycle with a strobe high. Next edge: strobes go to 0, ack[w] goes to 1, state goes to DONE.
  - DONE: ack[w] is high for this cycle only. rdata = ram_rdata when the access was a read; otherwise rdata holds its previous value.
- Transitions out of DONE (arbitration happens in the same edge, so there is no IDLE bubble):
  - If lock[w] && req[w] && burst_cnt < MAX_BURST-1: re-issue to w, burst_cnt++, go to ISSUE.
  - Otherwise: last_owner = w, burst_cnt = 0. Arbitrate over req with bit w masked. If there is a winner, go to ISSUE; else gnt = 0 and go to IDLE.
- Latency:
  - Request in IDLE to strobe: 1 cycle.
  - Strobe to ack: 1 cycle.
  - Sustained throughput: 1 access per 2 cycles.
- A requester whose req is sampled high must keep req, we, addr and wdata stable until its ack. Dropping req before ack is illegal: the access still completes and the ack is still pulsed.
- A requester that is the only one requesting is re-granted after the masked DONE cycle, going through IDLE (3-cycle spacing). The mask applies only to the arbitration done in DONE.
- The lock bit is ignored except in DONE. A burst is capped at MAX_BURST total accesses, after which ownership rotates.
- Invariants:
  - At most one gnt bit and at most one ack bit are high.
  - ram_we and ram_re are never high together.
  - gnt stays constant from ISSUE through DONE.
- Simultaneous requests in IDLE resolve strictly by round-robin order; there are no ties.

Optional Feature:
- ARB_FIXED_PRIO_EN
  - Defined: arbitration is fixed priority, lowest index wins (CPU always first). The DONE mask still applies for one arbitration. last_owner is unused.
  - Undefined: round-robin exactly as described above.

Test Plan:
- Single CPU read: req=3'b001, we=0, addr=16'h0040, RAM holds 16'hBEEF at 0x0040 -> ram_re high in cycle 1, ack[0] in cycle 2 with rdata=16'hBEEF, gnt=0 in cycle 3.
- Write: req[2]=1, we[2]=1, addr=16'h1234, wdata=16'h00A5 -> ram_we high for exactly 1 cycle with ram_addr=16'h1234 and ram_wdata=16'h00A5, then ack[2] pulses.
- Contention: req=3'b111 held, reset state -> grant order 0,1,2,0 with 2-cycle spacing. With ARB_FIXED_PRIO_EN: order 0,1,0,1 while req[0] is re-asserted.
- Locked burst: req[1]=1 and lock[1]=1 continuously, req[0]=1, MAX_BURST=4 -> 4 back-to-back accesses to port 1 (ISSUE/DONE alternating), then gnt=3'b001.
- Reset mid-access: assert RESET_N low during the ISSUE of a write -> the next cycle shows ram_we=0, ack=0, gnt=0, and the FSM is in IDLE.
- Idle/single requester: req=3'b001 re-asserted immediately after each ack -> accesses spaced 3 cycles apart, busy low in the IDLE cycle.
